// File: rtl/display_sched_pkg.sv
// Shared types and helpers for the display frame scheduler.
// Optional abort input is enabled by defining DISPLAY_SCHED_ABORT_EN.
package display_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    STREAM = 2'd2
  } sched_state_e;

  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;

  // Galois LFSR step; operands are zero-extended so any width up to 32 works.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'd0);
  endfunction

endpackage

// File: rtl/display_sched_lfsr.sv
// Evaluator seed register: loads a session seed (zero replaced by one so the
// Galois sequence can never lock at zero) and steps once per frame.
module display_sched_lfsr
  import display_sched_pkg::*;
#(
  parameter int                   RNDSIZE   = 16,
  parameter logic [RNDSIZE-1:0]   LFSR_TAPS = DEF_LFSR_TAPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [RNDSIZE-1:0] seed,
  output logic [RNDSIZE-1:0] state
);

  // Load has priority; the controller never asserts both in one cycle anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? RNDSIZE'(1) : seed;
    end else if (advance) begin
      state <= RNDSIZE'(lfsr_next(32'(state), 32'(LFSR_TAPS)));
    end
  end

endmodule

// File: rtl/display_frame_scheduler.sv
// Multi-frame session controller around the combinational display datapath.
// Latches one message configuration, evaluates one frame per LFSR step and
// streams each frame row by row over valid/ready.
// Define DISPLAY_SCHED_ABORT_EN to add the abort input.
//
// state  | meaning
// IDLE   | waiting for start with num_frames != 0
// EVAL   | one cycle: capture dp_pix into frame buffer, rewind row index
// STREAM | present rows; last row of last frame ends the session
module display_frame_scheduler
  import display_sched_pkg::*;
#(
  parameter int                 WIDTH       = 56,
  parameter int                 HEIGHT      = 24,
  parameter int                 NB_SEGMENTS = 70,
  parameter int                 RNDSIZE     = 16,
  parameter logic [RNDSIZE-1:0] LFSR_TAPS   = DEF_LFSR_TAPS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
`ifdef DISPLAY_SCHED_ABORT_EN
  input  logic                        abort,
`endif
  input  logic [7:0]                  num_frames,
  input  logic [RNDSIZE-1:0]          seed,
  input  logic                        z_in,
  input  logic [NB_SEGMENTS-1:0]      msg_in,
  input  logic [WIDTH*HEIGHT-1:0]     watmk_in,
  output logic                        dp_z,
  output logic [NB_SEGMENTS-1:0]      dp_msg,
  output logic [WIDTH*HEIGHT-1:0]     dp_watmk,
  output logic [RNDSIZE-1:0]          dp_rnd,
  input  logic [WIDTH*HEIGHT-1:0]     dp_pix,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic [WIDTH-1:0]            row_data,
  output logic [$clog2(HEIGHT)-1:0]   row_idx,
  output logic [7:0]                  frame_idx,
  output logic                        last_row,
  output logic                        busy,
  output logic                        done
);

  localparam int                NPIX     = WIDTH * HEIGHT;
  localparam int                ROWW     = $clog2(HEIGHT);
  localparam logic [ROWW-1:0]   LAST_ROW = ROWW'(HEIGHT - 1);

  sched_state_e             state_q, state_d;
  logic                     z_q;
  logic [NB_SEGMENTS-1:0]   msg_q;
  logic [NPIX-1:0]          watmk_q;
  logic [7:0]               nf_q;
  logic [7:0]               frame_idx_q;
  logic [ROWW-1:0]          row_idx_q;
  logic [NPIX-1:0]          frame_buf_q;
  logic                     done_q;

  logic                     abort_w;
  logic                     xfer;
  logic                     at_last_row;
  logic                     final_frame;
  logic                     accept;
  logic                     capture;
  logic                     row_inc;
  logic                     frame_adv;
  logic                     finish;

`ifdef DISPLAY_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign row_valid   = (state_q == STREAM);
  assign xfer        = row_valid & row_ready;
  assign at_last_row = (row_idx_q == LAST_ROW);
  assign final_frame = (frame_idx_q == nf_q - 8'd1);

  // Next-state and strobe decode; abort wins over a simultaneous transfer.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    row_inc   = 1'b0;
    frame_adv = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && num_frames != 8'd0) begin
          accept  = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (abort_w) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (abort_w) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (xfer) begin
          if (!at_last_row) begin
            row_inc = 1'b1;
          end else if (final_frame) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_adv = 1'b1;
            state_d   = EVAL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched configuration and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      z_q         <= 1'b0;
      msg_q       <= '0;
      watmk_q     <= '0;
      nf_q        <= '0;
      frame_idx_q <= '0;
      row_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (accept) begin
        z_q         <= z_in;
        msg_q       <= msg_in;
        watmk_q     <= watmk_in;
        nf_q        <= num_frames;
        frame_idx_q <= '0;
      end
      if (capture) row_idx_q <= '0;
      else if (row_inc) row_idx_q <= row_idx_q + 1'b1;
      if (frame_adv) frame_idx_q <= frame_idx_q + 8'd1;
    end
  end

  // Frame buffer holds no meaningful reset value; it is always captured before use.
  always_ff @(posedge clk) begin
    if (capture) frame_buf_q <= dp_pix;
  end

  display_sched_lfsr #(
    .RNDSIZE   (RNDSIZE),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance (frame_adv),
    .seed    (seed),
    .state   (dp_rnd)
  );

  assign dp_z      = z_q;
  assign dp_msg    = msg_q;
  assign dp_watmk  = watmk_q;
  assign row_data  = row_valid ? frame_buf_q[row_idx_q*WIDTH +: WIDTH] : '0;
  assign row_idx   = row_idx_q;
  assign frame_idx = frame_idx_q;
  assign last_row  = row_valid & at_last_row;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_display_frame_scheduler.sv
// Randomized self-checking bench for display_frame_scheduler with a stand-in
// datapath and a frame/row-level reference model.
// Define DISPLAY_SCHED_ABORT_EN to also exercise the abort input.
module tb_display_frame_scheduler;

  localparam int          WIDTH  = 56;
  localparam int          HEIGHT = 24;
  localparam int          NSEG   = 70;
  localparam int          RND    = 16;
  localparam int          NPIX   = WIDTH * HEIGHT;
  localparam logic [15:0] TAPS   = 16'hB400;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
`ifdef DISPLAY_SCHED_ABORT_EN
  logic                      abort = 1'b0;
`endif
  logic [7:0]                num_frames = '0;
  logic [RND-1:0]            seed = '0;
  logic                      z_in = 1'b0;
  logic [NSEG-1:0]           msg_in = '0;
  logic [NPIX-1:0]           watmk_in = '0;
  logic                      dp_z;
  logic [NSEG-1:0]           dp_msg;
  logic [NPIX-1:0]           dp_watmk;
  logic [RND-1:0]            dp_rnd;
  logic [NPIX-1:0]           dp_pix;
  logic                      row_valid;
  logic                      row_ready = 1'b0;
  logic [WIDTH-1:0]          row_data;
  logic [$clog2(HEIGHT)-1:0] row_idx;
  logic [7:0]                frame_idx;
  logic                      last_row;
  logic                      busy;
  logic                      done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [15:0] rnd_seen [0:255];

  display_frame_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef DISPLAY_SCHED_ABORT_EN
    .abort      (abort),
`endif
    .num_frames (num_frames),
    .seed       (seed),
    .z_in       (z_in),
    .msg_in     (msg_in),
    .watmk_in   (watmk_in),
    .dp_z       (dp_z),
    .dp_msg     (dp_msg),
    .dp_watmk   (dp_watmk),
    .dp_rnd     (dp_rnd),
    .dp_pix     (dp_pix),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .row_idx    (row_idx),
    .frame_idx  (frame_idx),
    .last_row   (last_row),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: any deterministic mix of all four inputs will do.
  function automatic logic [NPIX-1:0] pix_fn(input logic z, input logic [NSEG-1:0] m,
                                             input logic [NPIX-1:0] w, input logic [15:0] r);
    logic [NPIX-1:0] p;
    for (int i = 0; i < NPIX; i++) begin
      p[i] = w[i] ^ m[(i * 7) % NSEG] ^ r[(i + i / 16) % 16] ^ (z & i[0]);
    end
    return p;
  endfunction

  always_comb dp_pix = pix_fn(dp_z, dp_msg, dp_watmk, dp_rnd);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  function automatic logic [NPIX-1:0] rand_pix();
    logic [NPIX-1:0] v;
    for (int i = 0; i < NPIX; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NSEG-1:0] rand_msg();
    return NSEG'({$urandom, $urandom, $urandom});
  endfunction

  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One session: drive start, then walk frame by frame against the model.
  // Returns early (stopped=1) at the negedge where frame stop_f row stop_r is presented.
  task automatic run_session(input int nf, input logic [15:0] sd, input int duty,
                             input bit poke, input int stop_f, input int stop_r,
                             output bit stopped);
    logic            z;
    logic [NSEG-1:0] m;
    logic [NPIX-1:0] w;
    logic [NPIX-1:0] exp_pix;
    logic [15:0]     s;
    int              dc0;
    int              budget;
    bit              xf;
    z = 1'($urandom);
    m = rand_msg();
    w = rand_pix();
    dc0 = done_cnt;
    stopped = 1'b0;
    @(negedge clk);
    start = 1'b1; num_frames = 8'(nf); seed = sd; z_in = z; msg_in = m; watmk_in = w;
    @(negedge clk);
    start = 1'b0; num_frames = 8'($urandom); seed = 16'($urandom);
    z_in = ~z; msg_in = ~m; watmk_in = rand_pix();
    s = (sd == 16'h0) ? 16'h0001 : sd;
    for (int f = 0; f < nf; f++) begin
      rnd_seen[f] = dp_rnd;
      check("eval_valid", 64'(row_valid), 64'd0);
      check("eval_busy", 64'(busy), 64'd1);
      check("eval_rnd", 64'(dp_rnd), 64'(s));
      check("eval_frame_idx", 64'(frame_idx), 64'(f));
      check("eval_z", 64'(dp_z), 64'(z));
      check("eval_msg_eq", 64'(dp_msg == m), 64'd1);
      check("eval_watmk_eq", 64'(dp_watmk == w), 64'd1);
      exp_pix = pix_fn(z, m, w, s);
      @(negedge clk);
      for (int r = 0; r < HEIGHT; r++) begin
        if (f == stop_f && r == stop_r) begin
          stopped = 1'b1;
          return;
        end
        budget = 0;
        xf = 1'b0;
        while (!xf) begin
          check("row_valid", 64'(row_valid), 64'd1);
          check("row_idx", 64'(row_idx), 64'(r));
          check("row_data", 64'(row_data), 64'(exp_pix[r*WIDTH +: WIDTH]));
          check("last_row", 64'(last_row), 64'(r == HEIGHT - 1));
          check("frame_idx", 64'(frame_idx), 64'(f));
          check("stream_rnd", 64'(dp_rnd), 64'(s));
          check("stream_done", 64'(done), 64'd0);
          if (poke && f == 0 && r == 3 && budget == 0) begin
            start = 1'b1; num_frames = 8'd1; seed = 16'h1234;
          end else begin
            start = 1'b0;
          end
          row_ready = (budget >= 40) || ($urandom_range(99) < duty);
          xf = row_ready;
          budget++;
          @(negedge clk);
        end
      end
      if (f < nf - 1) s = lfsr_step(s);
    end
    start = 1'b0;
    row_ready = 1'b0;
    check("end_done", 64'(done), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("end_valid", 64'(row_valid), 64'd0);
    check("done_count", 64'(done_cnt - dc0), 64'd1);
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'd0);
  endtask

  initial begin
    bit stopped;
    int dc0;
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit stopped;
    int dc0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(row_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rnd", 64'(dp_rnd), 64'd0);
    check("rst_frame_idx", 64'(frame_idx), 64'd0);
    check("rst_row_idx", 64'(row_idx), 64'd0);
    check("rst_row_data", 64'(row_data), 64'd0);
    check("rst_last_row", 64'(last_row), 64'd0);
    check("rst_dp_z", 64'(dp_z), 64'd0);
    rst = 1'b0;

    run_session(1, 16'h0001, 100, 1'b0, -1, -1, stopped);
    check("s1_rnd0", 64'(rnd_seen[0]), 64'h0001);

    run_session(3, 16'h0001, 100, 1'b0, -1, -1, stopped);
    check("s3_rnd0", 64'(rnd_seen[0]), 64'h0001);
    check("s3_rnd1", 64'(rnd_seen[1]), 64'hB400);
    check("s3_rnd2", 64'(rnd_seen[2]), 64'h5A00);

    run_session(2, 16'h0000, 30, 1'b0, -1, -1, stopped);
    check("seed0_rnd0", 64'(rnd_seen[0]), 64'h0001);

    run_session(3, 16'($urandom), 30, 1'b1, -1, -1, stopped);

    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; num_frames = 8'd0; seed = 16'h00AA;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("nf0_busy", 64'(busy), 64'd0);
      check("nf0_valid", 64'(row_valid), 64'd0);
      @(negedge clk);
    end
    check("nf0_no_done", 64'(done_cnt - dc0), 64'd0);

    dc0 = done_cnt;
    run_session(3, 16'h0001, 100, 1'b0, 1, 5, stopped);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 64'(row_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rnd", 64'(dp_rnd), 64'd0);
    check("midrst_frame_idx", 64'(frame_idx), 64'd0);
    @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - dc0), 64'd0);
    run_session(2, 16'($urandom), 50, 1'b0, -1, -1, stopped);

`ifdef DISPLAY_SCHED_ABORT_EN
    dc0 = done_cnt;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_ignored", 64'(done_cnt - dc0), 64'd0);
    run_session(3, 16'h0001, 100, 1'b0, 1, 5, stopped);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    row_ready = 1'b0;
    check("abort_valid", 64'(row_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd1);
    @(negedge clk);
    check("abort_done_once", 64'(done_cnt - dc0), 64'd1);
    run_session(1, 16'($urandom), 50, 1'b0, -1, -1, stopped);
`endif

    for (int k = 0; k < 3; k++) begin
      run_session(int'($urandom_range(4, 1)), 16'($urandom), int'($urandom_range(90, 20)),
                  1'b0, -1, -1, stopped);
    end

    run_session(255, 16'($urandom), 100, 1'b0, -1, -1, stopped);
    check("nf255_last_frame_idx", 64'(frame_idx), 64'd254);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
